// File: rtl/nonce_arbiter_pkg.sv
// Shared definitions for the nonce arbiter: transmit FSM encoding, default
// parameter values and a constant-foldable clog2 helper.
package nonce_arbiter_pkg;

  localparam int unsigned DefSlaves    = 5;
  localparam int unsigned DefFifoDepth = 8;
  localparam int unsigned DefNonceW    = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } tx_state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Result FIFO for the nonce arbiter. Power-of-two depth so pointers wrap
// naturally; a push into a full FIFO is accepted only alongside a pop.
module nonce_fifo import nonce_arbiter_pkg::*; #(
  parameter int unsigned WIDTH = DefNonceW,
  parameter int unsigned DEPTH = DefFifoDepth
) (
  input  logic                   uart_clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == (AW + 1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  // Storage array: no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge uart_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/nonce_arbiter.sv
// Nonce arbiter: collects nonces from SLAVES sources into per-slave pending
// registers, grants one per cycle round-robin into a result FIFO, and feeds
// the serial transmitter through a four-state handshake FSM.
// Optional feature: define NONCE_DEDUP_EN to suppress a popped word equal to
// the last word sent.
module nonce_arbiter import nonce_arbiter_pkg::*; #(
  parameter int unsigned SLAVES     = DefSlaves,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned NONCE_W    = DefNonceW
) (
  input  logic                        uart_clk,
  input  logic                        reset,
  input  logic [SLAVES-1:0]           new_nonces,
  input  logic [SLAVES*NONCE_W-1:0]   slave_nonces,
  output logic [NONCE_W-1:0]          golden_nonce,
  output logic                        serial_send,
  input  logic                        serial_busy,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                 drop_count,
  output logic                        found
);

  localparam int unsigned SW = (SLAVES > 1) ? clog2(SLAVES) : 1;

  logic [SLAVES-1:0]  pending_q;
  logic [NONCE_W-1:0] pend_nonce_q [SLAVES];
  logic [SW-1:0]      last_grant_q;
  logic [SW-1:0]      grant_idx;
  logic               grant;
  logic [15:0]        drop_count_q;
  logic [15:0]        drop_count_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic [NONCE_W-1:0] fifo_head;
  logic               pop;
  logic               send_ok;

  tx_state_e          state_q;
  logic [NONCE_W-1:0] golden_nonce_q;
  logic               serial_send_q;
  logic               found_q;

  // Round-robin pick: scan from last_grant+1 upward; walking the offsets in
  // reverse lets the closest pending slave win without an early exit.
  always_comb begin
    int unsigned idx;
    grant     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < SLAVES; k++) begin
      idx = (32'(last_grant_q) + SLAVES - k) % SLAVES;
      if (pending_q[idx[SW-1:0]] && !fifo_full) begin
        grant     = 1'b1;
        grant_idx = idx[SW-1:0];
      end
    end
  end

  // Count overwrites of still-pending, ungranted entries; saturate at 16 bits.
  always_comb begin
    logic [4:0]  drops;
    logic [16:0] drop_sum;
    drops = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (new_nonces[i] && pending_q[i] && !(grant && grant_idx == SW'(i))) begin
        drops = drops + 5'd1;
      end
    end
    drop_sum     = {1'b0, drop_count_q} + {12'd0, drops};
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Pending registers, grant history and drop counter.
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      pending_q    <= '0;
      last_grant_q <= SW'(SLAVES - 1);
      drop_count_q <= '0;
      for (int i = 0; i < SLAVES; i++) pend_nonce_q[i] <= '0;
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (new_nonces[i]) begin
          // A strobe on the granted slave refills it in the same cycle.
          pending_q[i]    <= 1'b1;
          pend_nonce_q[i] <= slave_nonces[i*NONCE_W +: NONCE_W];
        end else if (grant && grant_idx == SW'(i)) begin
          pending_q[i] <= 1'b0;
        end
      end
      if (grant) last_grant_q <= grant_idx;
      drop_count_q <= drop_count_d;
    end
  end

  nonce_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .uart_clk  (uart_clk),
    .reset     (reset),
    .push      (grant),
    .push_data (pend_nonce_q[grant_idx]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign pop = (state_q == StIdle) && !fifo_empty && !serial_busy;

`ifdef NONCE_DEDUP_EN
  logic last_valid_q;

  // Repeat of the previously sent word is popped and silently dropped.
  assign send_ok = !(last_valid_q && (fifo_head == golden_nonce_q));

  // Marks golden_nonce as holding a genuinely sent word.
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      last_valid_q <= 1'b0;
    end else if (pop && send_ok) begin
      last_valid_q <= 1'b1;
    end
  end
`else
  assign send_ok = 1'b1;
`endif

  // Transmit FSM with registered strobes; serial_send rises the cycle after pop.
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      state_q        <= StIdle;
      golden_nonce_q <= '0;
      serial_send_q  <= 1'b0;
      found_q        <= 1'b0;
    end else begin
      serial_send_q <= 1'b0;
      found_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop && send_ok) begin
            golden_nonce_q <= fifo_head;
            serial_send_q  <= 1'b1;
            found_q        <= 1'b1;
            state_q        <= StSend;
          end
        end
        StSend:  state_q <= StHold;
        // One blind cycle while the transmitter raises busy.
        StHold:  state_q <= StDrain;
        StDrain: if (!serial_busy) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign golden_nonce = golden_nonce_q;
  assign serial_send  = serial_send_q;
  assign found        = found_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_nonce_arbiter.sv
// Scoreboard bench for nonce_arbiter: directed stimulus pushes expected words,
// a monitor pops and compares on every serial_send.
module tb_nonce_arbiter;

  localparam int unsigned SLAVES     = 5;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned NONCE_W    = 32;

  logic                      uart_clk = 1'b0;
  logic                      reset;
  logic [SLAVES-1:0]         new_nonces;
  logic [SLAVES*NONCE_W-1:0] slave_nonces;
  logic [NONCE_W-1:0]        golden_nonce;
  logic                      serial_send;
  logic                      serial_busy;
  logic [3:0]                fifo_level;
  logic [15:0]               drop_count;
  logic                      found;

  logic       busy_manual;
  logic       tx_auto;
  logic [2:0] busy_cnt = 3'd0;

  logic [31:0] sb [$];
  int checks   = 0;
  int errors   = 0;
  int send_cnt = 0;

  always #5 uart_clk = ~uart_clk;

  nonce_arbiter #(
    .SLAVES     (SLAVES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .NONCE_W    (NONCE_W)
  ) dut (
    .uart_clk     (uart_clk),
    .reset        (reset),
    .new_nonces   (new_nonces),
    .slave_nonces (slave_nonces),
    .golden_nonce (golden_nonce),
    .serial_send  (serial_send),
    .serial_busy  (serial_busy),
    .fifo_level   (fifo_level),
    .drop_count   (drop_count),
    .found        (found)
  );

  // Simple transmitter: busy for three cycles after each send request.
  assign serial_busy = busy_manual | (busy_cnt != 3'd0);
  always @(posedge uart_clk) begin
    if (reset) busy_cnt <= 3'd0;
    else if (tx_auto && serial_send) busy_cnt <= 3'd3;
    else if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every send must match the head of the scoreboard.
  initial forever begin
    @(negedge uart_clk);
    if (reset === 1'b0 && serial_send === 1'b1) begin
      send_cnt++;
      check("send_expected", 32'(sb.size() != 0), 32'd1);
      check("found_with_send", 32'(found), 32'd1);
      if (sb.size() != 0) check("golden_nonce", golden_nonce, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge uart_clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    new_nonces = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic strobe(input int s, input logic [31:0] v);
    new_nonces[s] = 1'b1;
    slave_nonces[s*NONCE_W +: NONCE_W] = v;
    tick();
    new_nonces = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, sb.size(), 0);
    repeat (10) tick();
  endtask

  initial begin
    int base;
    reset        = 1'b1;
    new_nonces   = '0;
    slave_nonces = '0;
    busy_manual  = 1'b0;
    tx_auto      = 1'b0;
    repeat (2) tick();

    // Reset values
    do_reset();
    check("rst_golden", golden_nonce, 32'h0);
    check("rst_send", 32'(serial_send), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);

    // Single nonce: send three cycles after the strobe, one-cycle pulses
    sb.push_back(32'hDEADBEEF);
    strobe(2, 32'hDEADBEEF);
    tick();
    tick();
    check("latency_send", 32'(serial_send), 32'd1);
    check("latency_found", 32'(found), 32'd1);
    tick();
    check("send_one_pulse", 32'(serial_send), 32'd0);
    check("found_one_pulse", 32'(found), 32'd0);
    check("golden_stable", golden_nonce, 32'hDEADBEEF);
    wait_drain("single_drain", 50);

    // All slaves at once after reset (last_grant=4): order 0..4
    do_reset();
    tx_auto = 1'b1;
    base = send_cnt;
    for (int i = 0; i < 5; i++) begin
      new_nonces[i] = 1'b1;
      slave_nonces[i*NONCE_W +: NONCE_W] = 32'hA000_0000 + 32'(i);
      sb.push_back(32'hA000_0000 + 32'(i));
    end
    tick();
    new_nonces = '0;
    wait_drain("rr_drain", 200);
    check("rr_send_count", 32'(send_cnt - base), 32'd5);

    // Busy held: FIFO fills to 8, one pending, three overwrites
    do_reset();
    tx_auto     = 1'b0;
    busy_manual = 1'b1;
    for (int k = 0; k < 12; k++) begin
      strobe(0, 32'h100 + 32'(k));
      tick();
    end
    repeat (2) tick();
    check("full_level", 32'(fifo_level), 32'd8);
    check("full_drops", 32'(drop_count), 32'd3);
    for (int k = 0; k < 8; k++) sb.push_back(32'h100 + 32'(k));
    sb.push_back(32'h10B);
    busy_manual = 1'b0;
    tx_auto     = 1'b1;
    wait_drain("full_drain", 300);
    check("full_level_after", 32'(fifo_level), 32'd0);

    // Back-to-back strobes while full: second value kept, one drop
    do_reset();
    tx_auto     = 1'b0;
    busy_manual = 1'b1;
    for (int k = 0; k < 8; k++) begin
      new_nonces[0] = 1'b1;
      slave_nonces[0 +: NONCE_W] = 32'h200 + 32'(k);
      tick();
    end
    new_nonces = '0;
    repeat (2) tick();
    check("refill_no_drop", 32'(drop_count), 32'd0);
    check("refill_level", 32'(fifo_level), 32'd8);
    strobe(1, 32'h301);
    strobe(1, 32'h302);
    tick();
    check("overwrite_drop", 32'(drop_count), 32'd1);
    for (int k = 0; k < 8; k++) sb.push_back(32'h200 + 32'(k));
    sb.push_back(32'h302);
    busy_manual = 1'b0;
    tx_auto     = 1'b1;
    wait_drain("overwrite_drain", 300);

    // Reset while draining with four queued words
    do_reset();
    tx_auto     = 1'b0;
    busy_manual = 1'b0;
    sb.push_back(32'h5555_0003);
    strobe(3, 32'h5555_0003);
    tick();
    tick();
    busy_manual = 1'b1;
    for (int k = 0; k < 4; k++) begin
      new_nonces[0] = 1'b1;
      slave_nonces[0 +: NONCE_W] = 32'h400 + 32'(k);
      tick();
    end
    new_nonces = '0;
    repeat (3) tick();
    check("drain_level", 32'(fifo_level), 32'd4);
    base = send_cnt;
    reset = 1'b1;
    tick();
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_send", 32'(serial_send), 32'd0);
    reset       = 1'b0;
    busy_manual = 1'b0;
    repeat (10) tick();
    check("midrst_no_send", 32'(send_cnt - base), 32'd0);

    // Same word twice in succession
    do_reset();
    tx_auto = 1'b1;
    base    = send_cnt;
    sb.push_back(32'h12345678);
`ifndef NONCE_DEDUP_EN
    sb.push_back(32'h12345678);
`endif
    strobe(0, 32'h12345678);
    repeat (15) tick();
    strobe(0, 32'h12345678);
    repeat (15) tick();
    wait_drain("dup_drain", 100);
`ifdef NONCE_DEDUP_EN
    check("dup_send_count", 32'(send_cnt - base), 32'd1);
`else
    check("dup_send_count", 32'(send_cnt - base), 32'd2);
`endif

    check("sb_empty_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
